// File: rtl/decode_issue_queue.sv
// Decode/issue queue between fetch and the Alpha/Beta decode lanes of the dual-issue MIPS pipeline.
// Build option: define DECODE_QUEUE_DUAL_ISSUE_EN for dual issue; otherwise at most one instruction issues per cycle.
module decode_issue_queue #(
  parameter int DEPTH    = 8,
  parameter int IN_LANES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [IN_LANES-1:0]      in_valid,
  input  logic [32*IN_LANES-1:0]   in_inst,
  input  logic [32*IN_LANES-1:0]   in_pc,
  output logic                     in_ready,
  input  logic                     issue_ready,
  output logic [1:0]               issue_count,
  output logic [63:0]              issue_inst,
  output logic [63:0]              issue_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [2:0] CLS_ALU   = 3'd0;
  localparam logic [2:0] CLS_MEM   = 3'd1;
  localparam logic [2:0] CLS_HILO  = 3'd2;
  localparam logic [2:0] CLS_BR    = 3'd3;
  localparam logic [2:0] CLS_PRIV  = 3'd4;
  localparam logic [2:0] CLS_UNDEF = 3'd5;

  typedef struct packed {
    logic [4:0] dest;
    logic       wen;
    logic       rs_used;
    logic       rt_used;
    logic [2:0] cls;
  } dec_t;

  function automatic dec_t predecode(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] funct);
    dec_t d;
    d     = '0;
    d.cls = CLS_UNDEF;
    casez (op)
      6'b000000: begin
        d.dest = rd;
        casez (funct)
          6'b000000, 6'b000010, 6'b000011: begin
            d.cls = CLS_ALU; d.wen = 1'b1; d.rt_used = 1'b1;
          end
          6'b000100, 6'b000110, 6'b000111, 6'b100???, 6'b10101?: begin
            d.cls = CLS_ALU; d.wen = 1'b1; d.rs_used = 1'b1; d.rt_used = 1'b1;
          end
          6'b001000: begin d.cls = CLS_BR; d.rs_used = 1'b1; end
          6'b001001: begin d.cls = CLS_BR; d.rs_used = 1'b1; d.wen = 1'b1; end
          6'b001100, 6'b001101: d.cls = CLS_PRIV;
          6'b010000, 6'b010010: begin d.cls = CLS_HILO; d.wen = 1'b1; end
          6'b010001, 6'b010011: begin d.cls = CLS_HILO; d.rs_used = 1'b1; end
          6'b0110??: begin d.cls = CLS_HILO; d.rs_used = 1'b1; d.rt_used = 1'b1; end
          default: d.cls = CLS_UNDEF;
        endcase
      end
      6'b000001: begin
        // BLTZAL/BGEZAL link into $31
        d.cls = CLS_BR; d.rs_used = 1'b1; d.wen = rt[4]; d.dest = 5'd31;
      end
      6'b000010: d.cls = CLS_BR;
      6'b000011: begin d.cls = CLS_BR; d.wen = 1'b1; d.dest = 5'd31; end
      6'b0001??: begin d.cls = CLS_BR; d.rs_used = 1'b1; d.rt_used = ~op[1]; end
      6'b001???: begin
        d.cls = CLS_ALU; d.dest = rt; d.wen = 1'b1; d.rs_used = (op != 6'b001111);
      end
      6'b010000: begin
        d.cls     = CLS_PRIV;
        d.dest    = rt;
        d.wen     = (rs == 5'b00000);
        d.rt_used = (rs == 5'b00100);
      end
      6'b1?????: begin
        d.cls = CLS_MEM; d.rs_used = 1'b1; d.dest = rt;
        d.wen = ~op[3]; d.rt_used = op[3];
      end
      default: d.cls = CLS_UNDEF;
    endcase
    return d;
  endfunction

  logic [PTR_W-1:0] head_q, tail_q, head_b;
  logic [OCC_W-1:0] occ_q, push_n, issue_n;
  logic             do_push;
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  dec_t             dec_q  [DEPTH];
  dec_t             dec_in [IN_LANES];

  logic [2:0]       a_cls, b_cls;
  logic [4:0]       b_rs, b_rt;
  logic             raw_hazard, a_solo, b_solo;
  logic [1:0]       pair_count;

  assign in_ready = occ_q <= OCC_W'(DEPTH - IN_LANES);
  assign do_push  = in_ready && (|in_valid);

  always_comb begin
    push_n = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      push_n    = push_n + OCC_W'(in_valid[i]);
      dec_in[i] = predecode(in_inst[32*i+26 +: 6], in_inst[32*i+21 +: 5],
                            in_inst[32*i+16 +: 5], in_inst[32*i+11 +: 5],
                            in_inst[32*i +: 6]);
    end
  end

  assign issue_n = issue_ready ? OCC_W'(issue_count) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_q + PTR_W'(issue_n);
      if (do_push) tail_q <= tail_q + PTR_W'(push_n);
      occ_q  <= occ_q + (do_push ? push_n : '0) - issue_n;
    end
  end

  // NOTE: entry storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < IN_LANES; i++) begin
        if (in_valid[i]) begin
          inst_q[tail_q + PTR_W'(i)] <= in_inst[32*i +: 32];
          pc_q[tail_q + PTR_W'(i)]   <= in_pc[32*i +: 32];
          dec_q[tail_q + PTR_W'(i)]  <= dec_in[i];
        end
      end
    end
  end

  assign head_b = head_q + PTR_W'(1);
  assign a_cls  = dec_q[head_q].cls;
  assign b_cls  = dec_q[head_b].cls;
  assign b_rs   = inst_q[head_b][25:21];
  assign b_rt   = inst_q[head_b][20:16];
  assign a_solo = (a_cls == CLS_PRIV) || (a_cls == CLS_UNDEF);
  assign b_solo = (b_cls == CLS_PRIV) || (b_cls == CLS_UNDEF);

  assign raw_hazard = dec_q[head_q].wen && (dec_q[head_q].dest != 5'd0) &&
                      ((dec_q[head_b].rs_used && (b_rs == dec_q[head_q].dest)) ||
                       (dec_q[head_b].rt_used && (b_rt == dec_q[head_q].dest)));

  // NOTE: default first so every path assigns pair_count and no latch is inferred.
  always_comb begin
    pair_count = 2'd2;
    if (occ_q == '0)                                            pair_count = 2'd0;
    else if (a_cls == CLS_BR)                                   pair_count = (occ_q >= OCC_W'(2)) ? 2'd2 : 2'd0;
    else if (occ_q == OCC_W'(1))                                pair_count = 2'd1;
    else if (a_solo || b_solo)                                  pair_count = 2'd1;
    else if (b_cls == CLS_BR)                                   pair_count = 2'd1;
    else if (raw_hazard)                                        pair_count = 2'd1;
    else if ((a_cls == CLS_MEM) && (b_cls == CLS_MEM))          pair_count = 2'd1;
    else if ((a_cls == CLS_HILO) && (b_cls == CLS_HILO))        pair_count = 2'd1;
  end

`ifdef DECODE_QUEUE_DUAL_ISSUE_EN
  assign issue_count = pair_count;
`else
  // A head branch still waits for its slot; otherwise everything issues alone.
  assign issue_count = (pair_count != 2'd0) ? 2'd1 : 2'd0;
`endif

  assign issue_inst = {inst_q[head_b], inst_q[head_q]};
  assign issue_pc   = {pc_q[head_b], pc_q[head_q]};
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: pairing table, scoreboard of issued entries, corner sequences.
module tb_decode_issue_queue;
  localparam int DEPTH    = 8;
  localparam int IN_LANES = 2;
`ifdef DECODE_QUEUE_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  localparam logic [31:0] ADDU   = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] OR_I   = 32'h0086_2825; // or   $5,$4,$6
  localparam logic [31:0] SUBU   = 32'h0061_2023; // subu $4,$3,$1
  localparam logic [31:0] BEQ    = 32'h1022_0004;
  localparam logic [31:0] LW     = 32'h8D28_0000; // lw $8,0($9)
  localparam logic [31:0] SW     = 32'hAD6A_0004; // sw $10,4($11)
  localparam logic [31:0] MULT   = 32'h0022_0018;
  localparam logic [31:0] MFLO   = 32'h0000_3812; // mflo $7
  localparam logic [31:0] SYSC   = 32'h0000_000C;
  localparam logic [31:0] JAL    = 32'h0C00_0010;

  logic                   clk = 1'b0;
  logic                   rst, flush, issue_ready, in_ready;
  logic [IN_LANES-1:0]    in_valid;
  logic [32*IN_LANES-1:0] in_inst, in_pc;
  logic [1:0]             issue_count;
  logic [63:0]            issue_inst, issue_pc;
  logic [$clog2(DEPTH):0] occupancy;

  decode_issue_queue #(.DEPTH(DEPTH), .IN_LANES(IN_LANES)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_ready(in_ready), .issue_ready(issue_ready),
    .issue_count(issue_count), .issue_inst(issue_inst), .issue_pc(issue_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
  typedef struct { string name; logic [31:0] a; logic [31:0] b; int dual_cnt; } vec_t;

  entry_t      sb[$];
  vec_t        vecs[12];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  function automatic logic [31:0] addiu(input int k);
    return 32'h2400_0000 | (32'(k) << 16) | 32'(k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: compares issued lanes against the scoreboard, applies one clock edge.
  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic rdy, input logic fl);
    bit     acc;
    int     cnt;
    entry_t e;
    acc         = !fl && (v != 2'b00) && (sb.size() <= DEPTH - IN_LANES);
    in_valid    = v;
    in_inst     = {i1, i0};
    in_pc       = {pc_ctr + 32'd4, pc_ctr};
    issue_ready = rdy;
    flush       = fl;
    cnt         = int'(issue_count);
    if (rdy && !fl) begin
      if (cnt > sb.size()) check("issue_beyond_occupancy", 64'(cnt), 64'(sb.size()));
      else begin
        for (int k = 0; k < cnt; k++) begin
          e = sb.pop_front();
          check("issue_inst", 64'(issue_inst[32*k +: 32]), 64'(e.inst));
          check("issue_pc", 64'(issue_pc[32*k +: 32]), 64'(e.pc));
        end
      end
    end
    if (fl) sb.delete();
    else if (acc) begin
      if (v[0]) sb.push_back('{inst: i0, pc: pc_ctr});
      if (v[1]) sb.push_back('{inst: i1, pc: pc_ctr + 32'd4});
    end
    pc_ctr = pc_ctr + 32'd8;
    @(posedge clk);
    @(negedge clk);
    in_valid    = '0;
    flush       = 1'b0;
    issue_ready = 1'b0;
    check("occupancy", 64'(occupancy), 64'(sb.size()));
    check("in_ready", 64'(in_ready), 64'(sb.size() <= DEPTH - IN_LANES));
  endtask

  task automatic drain(input int target);
    for (int n = 0; n < 20 && sb.size() > target; n++) drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("drain_done", 64'(occupancy), 64'(target));
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    issue_ready = 1'b1;
    in_valid    = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    issue_ready = 1'b0;
    in_valid    = '0;
    sb.delete();
    check("reset_occupancy", 64'(occupancy), 64'd0);
    check("reset_issue_count", 64'(issue_count), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; issue_ready = 1'b0; in_valid = '0; in_inst = '0; in_pc = '0;
    vecs[0]  = '{"addu_or",      ADDU,         OR_I,          2};
    vecs[1]  = '{"raw_rs",       ADDU,         SUBU,          1};
    vecs[2]  = '{"raw_rt",       32'h2423_0001, 32'h0083_2821, 1};
    vecs[3]  = '{"zero_dest",    32'h0022_0021, 32'h0001_1821, 2};
    vecs[4]  = '{"load_use",     LW,           32'h0101_1821, 1};
    vecs[5]  = '{"mem_mem",      LW,           SW,            1};
    vecs[6]  = '{"hilo_hilo",    MULT,         MFLO,          1};
    vecs[7]  = '{"priv_a",       SYSC,         ADDU,          1};
    vecs[8]  = '{"undef_b",      ADDU,         32'h7000_0000, 1};
    vecs[9]  = '{"mem_alu",      LW,           ADDU,          2};
    vecs[10] = '{"alu_hilo",     ADDU,         MFLO,          2};
    vecs[11] = '{"br_raw_waived", JAL,         32'h03E1_1821, 2};

    @(negedge clk);
    do_reset();

    foreach (vecs[t]) begin
      drive(2'b11, vecs[t].a, vecs[t].b, 1'b0, 1'b0);
      check({vecs[t].name, "_count"}, 64'(issue_count), DUAL ? 64'(vecs[t].dual_cnt) : 64'd1);
      drain(0);
    end

    // Two separate partial pushes with a RAW dependency.
    drive(2'b01, ADDU, '0, 1'b0, 1'b0);
    check("single_head_count", 64'(issue_count), 64'd1);
    drive(2'b01, SUBU, '0, 1'b0, 1'b0);
    check("raw_split_count", 64'(issue_count), 64'd1);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("subu_alone_count", 64'(issue_count), 64'd1);
    drain(0);

    // Branch waits for its delay slot.
    drive(2'b01, BEQ, '0, 1'b0, 1'b0);
    check("br_wait_count", 64'(issue_count), 64'd0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("br_still_wait_count", 64'(issue_count), 64'd0);
    drive(2'b01, ADDU, '0, 1'b0, 1'b0);
    check("br_slot_count", 64'(issue_count), DUAL ? 64'd2 : 64'd1);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("after_br_group_count", 64'(issue_count), DUAL ? 64'd0 : 64'd1);
    drain(0);

    // Branch in lane B is held back to become the next head.
    drive(2'b11, ADDU, BEQ, 1'b0, 1'b0);
    check("br_in_b_count", 64'(issue_count), 64'd1);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("br_head_alone_count", 64'(issue_count), 64'd0);
    drive(2'b01, OR_I, '0, 1'b0, 1'b0);
    check("br_b_slot_count", 64'(issue_count), DUAL ? 64'd2 : 64'd1);
    drain(0);

    // Full queue, ignored pushes, partial drain, pointer wrap.
    do_reset();
    drive(2'b11, addiu(1), addiu(2), 1'b0, 1'b0);
    drive(2'b11, addiu(3), addiu(4), 1'b0, 1'b0);
    drive(2'b11, addiu(5), addiu(6), 1'b0, 1'b0);
    drive(2'b01, addiu(7), '0, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(2'b11, addiu(8), addiu(9), 1'b0, 1'b0);
    check("full_ignored_occupancy", 64'(occupancy), 64'd7);
    drain(5);
    check("drained_in_ready", 64'(in_ready), 64'd1);
    drain(0);
    drive(2'b11, ADDU, OR_I, 1'b0, 1'b0);
    check("wrap_pair_count", 64'(issue_count), DUAL ? 64'd2 : 64'd1);
    drain(0);

    // Reset with live entries.
    drive(2'b11, ADDU, OR_I, 1'b0, 1'b0);
    do_reset();

    // Flush overrides a simultaneous push and dequeue.
    drive(2'b11, addiu(1), addiu(2), 1'b0, 1'b0);
    drive(2'b11, addiu(3), addiu(4), 1'b0, 1'b0);
    drive(2'b01, addiu(5), '0, 1'b0, 1'b0);
    check("pre_flush_occupancy", 64'(occupancy), 64'd5);
    drive(2'b11, ADDU, OR_I, 1'b1, 1'b1);
    check("flush_issue_count", 64'(issue_count), 64'd0);
    drive(2'b11, ADDU, OR_I, 1'b0, 1'b0);
    check("post_flush_count", 64'(issue_count), DUAL ? 64'd2 : 64'd1);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
